// File: rtl/keccak_pad_stream_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : keccak_pad_stream_if                                            |
// | Purpose  : Beat-in / padded-block-out handshake bundle for the padder.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface keccak_pad_stream_if #(
    parameter int RATE = 1088,
    parameter int W    = 64
);
    logic                   in_valid;
    logic                   in_ready;
    logic [W-1:0]           in_data;
    logic [$clog2(W+1)-1:0] in_bits;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [RATE-1:0]        out_block;
    logic                   out_last;

    modport master (
        output in_valid, in_data, in_bits, in_last, out_ready,
        input  in_ready, out_valid, out_block, out_last
    );

    modport slave (
        input  in_valid, in_data, in_bits, in_last, out_ready,
        output in_ready, out_valid, out_block, out_last
    );
endinterface
`default_nettype wire

// File: rtl/keccak_pad_stream.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : keccak_pad_stream                                               |
// | Purpose  : Streams W-bit beats into RATE-bit blocks, appends domain suffix |
// |            and pad10*1, spilling to a second block when padding overflows.|
// |            Define KPAD_ERR_EN to add the sticky err output.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module keccak_pad_stream #(
    parameter int         RATE       = 1088,
    parameter int         W          = 64,
    parameter int         SUFFIX_LEN = 4,
    parameter logic [7:0] SUFFIX     = 8'b0000_1111
) (
    input  wire logic          clk,
    input  wire logic          rst,
    keccak_pad_stream_if.slave bus
`ifdef KPAD_ERR_EN
    ,
    output logic               err
`endif
);

    localparam int c_PW = $clog2(RATE + 1);
    localparam int c_BW = $clog2(W + 1);
    localparam int c_SW = $clog2(SUFFIX_LEN + 2);

    localparam logic [c_PW-1:0] c_RATE_P = c_PW'(RATE);
    localparam logic [c_PW-1:0] c_LIM    = c_PW'(SUFFIX_LEN + 1);
    localparam logic [c_BW-1:0] c_W_B    = c_BW'(W);

    // SUFFIX||1 left-justified in a block-wide vector; shifting it positions or consumes pad bits
    function automatic logic [RATE-1:0] pad_top();
        logic [RATE-1:0] v;
        v = '0;
        for (int i = 0; i < SUFFIX_LEN; i++) begin
            v[RATE-1-i] = SUFFIX[SUFFIX_LEN-1-i];
        end
        v[RATE-1-SUFFIX_LEN] = 1'b1;
        return v;
    endfunction

    localparam logic [RATE-1:0] c_PAD_TOP = pad_top();

    typedef enum logic [1:0] {
        S_FILL       = 2'd0,
        S_EMIT       = 2'd1,
        S_EMIT_SPILL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [RATE-1:0]   buf_q, buf_d;
    logic [c_PW-1:0]   ptr_q, ptr_d;
    logic              last_q, last_d;
    logic              spill_q, spill_d;
    logic [c_SW-1:0]   spill_n_q, spill_n_d;

    logic              w_take;
    logic [c_BW-1:0]   w_nbits;
    logic [W-1:0]      w_mask;
    logic [RATE-1:0]   w_beat;
    logic [RATE-1:0]   w_msg_buf;
    logic [c_PW-1:0]   w_ptr_new;
    logic [c_PW-1:0]   w_free;

    assign bus.in_ready  = (state_q == S_FILL) && !rst;
    assign bus.out_valid = (state_q != S_FILL);
    assign bus.out_block = buf_q;
    assign bus.out_last  = last_q;

    assign w_take    = bus.in_valid && (state_q == S_FILL);
    assign w_nbits   = !bus.in_last ? c_W_B :
                       ((bus.in_bits > c_W_B) ? c_W_B : bus.in_bits);
    assign w_mask    = ~({W{1'b1}} >> w_nbits);
    assign w_beat    = RATE'(bus.in_data & w_mask) << (RATE - W);
    assign w_msg_buf = buf_q | (w_beat >> ptr_q);
    assign w_ptr_new = ptr_q + c_PW'(w_nbits);
    assign w_free    = c_RATE_P - w_ptr_new;

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        ptr_d     = ptr_q;
        last_d    = last_q;
        spill_d   = spill_q;
        spill_n_d = spill_n_q;

        case (state_q)
            S_FILL: begin
                if (w_take) begin
                    buf_d = w_msg_buf;
                    ptr_d = w_ptr_new;
                    if (bus.in_last) begin
                        // Bits of SUFFIX||1 past bit [0] fall off the shift and go to the spill block
                        buf_d   = w_msg_buf | (c_PAD_TOP >> w_ptr_new);
                        state_d = S_EMIT;
                        if (w_free > c_LIM) begin
                            buf_d[0] = 1'b1;
                            last_d   = 1'b1;
                            spill_d  = 1'b0;
                        end else begin
                            last_d    = 1'b0;
                            spill_d   = 1'b1;
                            spill_n_d = c_SW'(w_free);
                        end
                    end else if (w_ptr_new == c_RATE_P) begin
                        last_d  = 1'b0;
                        state_d = S_EMIT;
                    end
                end
            end

            S_EMIT: begin
                if (bus.out_ready) begin
                    if (spill_q) begin
                        buf_d   = (c_PAD_TOP << spill_n_q) | RATE'(1);
                        last_d  = 1'b1;
                        spill_d = 1'b0;
                        state_d = S_EMIT_SPILL;
                    end else begin
                        buf_d   = '0;
                        ptr_d   = '0;
                        last_d  = 1'b0;
                        state_d = S_FILL;
                    end
                end
            end

            S_EMIT_SPILL: begin
                if (bus.out_ready) begin
                    buf_d   = '0;
                    ptr_d   = '0;
                    last_d  = 1'b0;
                    state_d = S_FILL;
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FILL;
            buf_q     <= '0;
            ptr_q     <= '0;
            last_q    <= 1'b0;
            spill_q   <= 1'b0;
            spill_n_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            ptr_q     <= ptr_d;
            last_q    <= last_d;
            spill_q   <= spill_d;
            spill_n_q <= spill_n_d;
        end
    end

`ifdef KPAD_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (w_take && !bus.in_last && (bus.in_bits != c_W_B)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    // Short non-last beats are silently widened to W bits.
`endif

endmodule
`default_nettype wire
